// File: rtl/ysyx_22041211_ifu_if.sv
// Fetch-side bundle of the IFU: redirect input, imem request/response channel, decoder handshake.
// The master modport is the IFU's view; the slave modport is the memory/decoder/back-end side.
interface ysyx_22041211_ifu_if;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] fetch_cnt_o;

    modport master (
        input  redirect_valid_i, redirect_pc_i,
        output imem_req_valid_o, imem_addr_o,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        output inst_valid_o, inst_o, pc_o, fetch_cnt_o,
        input  inst_ready_i
    );

    modport slave (
        output redirect_valid_i, redirect_pc_i,
        input  imem_req_valid_o, imem_addr_o,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        input  inst_valid_o, inst_o, pc_o, fetch_cnt_o,
        output inst_ready_i
    );
endinterface

// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch: one outstanding imem request, registered {inst, pc} to the decoder, redirects kill stale responses.
// Latency: imem response -> inst_valid 1 cycle, handshake -> next request 1 cycle; holds inst/pc while inst_ready is low.
module ysyx_22041211_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input logic                 clk,
    input logic                 rst,
    ysyx_22041211_ifu_if.master bus
);
    localparam logic [1:0] REQ  = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] inst_buf;
    logic [31:0] fetch_cnt;
    logic        kill;
    logic [31:0] target;
    logic        req_fire;

    assign target   = bus.redirect_pc_i & 32'hFFFF_FFFC;
    assign req_fire = (state == REQ) && bus.imem_req_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            state     <= REQ;
            kill      <= 1'b0;
            inst_buf  <= 32'd0;
            fetch_cnt <= 32'd0;
        end else begin
            case (state)
                REQ: begin
                    if (bus.redirect_valid_i) begin
                        pc <= target;
                    end
                    if (req_fire) begin
                        state <= WAIT;
                        // The accepted request is for the old pc; its response must be dropped.
                        kill  <= bus.redirect_valid_i;
                    end
                end
                WAIT: begin
                    if (bus.imem_rsp_valid_i) begin
                        kill <= 1'b0;
                        if (kill || bus.redirect_valid_i) begin
                            state <= REQ;
                        end else begin
                            inst_buf <= bus.imem_rsp_data_i;
                            state    <= OUT;
                        end
                        if (bus.redirect_valid_i) begin
                            pc <= target;
                        end
                    end else if (bus.redirect_valid_i) begin
                        pc   <= target;
                        kill <= 1'b1;
                    end
                end
                OUT: begin
                    // Redirect wins over a same-cycle consume: the buffered word is wrong-path.
                    if (bus.redirect_valid_i) begin
                        pc    <= target;
                        state <= REQ;
                    end else if (bus.inst_ready_i) begin
                        pc        <= pc + 32'd4;
                        fetch_cnt <= fetch_cnt + 32'd1;
                        state     <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    assign bus.imem_req_valid_o = (state == REQ);
    assign bus.imem_addr_o      = pc;
    assign bus.inst_valid_o     = (state == OUT);
    assign bus.inst_o           = inst_buf;
    assign bus.pc_o             = pc;
    assign bus.fetch_cnt_o      = fetch_cnt;
endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Bench for ysyx_22041211_ifu: directed scenarios plus random traffic against a program-order fetch model.
module tb_ysyx_22041211_ifu;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_22041211_ifu_if bus ();
    ysyx_22041211_ifu #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_chk  = 0;
    int          n_pass = 0;
    // Reference: next delivered instruction comes from the last redirect target + 4 per delivered instruction.
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    // Memory model: one pending request, response after lat cycles, stale if any redirect happened meanwhile.
    bit          pend;
    bit          stale;
    int          cd;
    logic [31:0] pend_addr;
    bit          want_valid, want_novalid, want_req, want_hold;
    logic [31:0] hold_inst;
    int          idle;
    logic [31:0] acc_q[$];
    logic [31:0] saved_pc, saved_inst, saved_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic step(input bit redir, input logic [31:0] tgt, input bit iready,
                        input bit mready, input int lat);
        bit rsp, hs, acc;
        rsp = 1'b0;
        if (pend) begin
            cd--;
            rsp = (cd == 0);
        end
        bus.redirect_valid_i = redir;
        bus.redirect_pc_i    = tgt;
        bus.inst_ready_i     = iready;
        bus.imem_req_ready_i = mready;
        bus.imem_rsp_valid_i = rsp;
        bus.imem_rsp_data_i  = rsp ? mem_word(pend_addr) : $urandom;
        #1;
        if (want_valid)   check("rsp_to_valid", 32'(bus.inst_valid_o), 32'd1);
        if (want_novalid) check("redirect_drops_valid", 32'(bus.inst_valid_o), 32'd0);
        if (want_req)     check("next_req", 32'(bus.imem_req_valid_o), 32'd1);
        if (want_hold) begin
            check("hold_valid", 32'(bus.inst_valid_o), 32'd1);
            check("hold_inst", bus.inst_o, hold_inst);
        end
        check("fetch_cnt", bus.fetch_cnt_o, m_cnt);
        if (bus.inst_valid_o) begin
            check("pc_o", bus.pc_o, m_pc);
            check("inst_o", bus.inst_o, mem_word(bus.pc_o));
        end
        if (bus.imem_req_valid_o) begin
            check("req_addr", bus.imem_addr_o, m_pc);
            check("one_outstanding", 32'(pend), 32'd0);
        end
        if (idle == 40) check("progress", 32'(idle), 32'd0);

        hs           = bus.inst_valid_o && iready && !redir;
        acc          = bus.imem_req_valid_o && mready;
        want_valid   = rsp && !stale && !redir;
        want_novalid = redir;
        want_req     = hs || (redir && bus.inst_valid_o);
        want_hold    = bus.inst_valid_o && !iready && !redir;
        hold_inst    = bus.inst_o;
        if (rsp) pend = 1'b0;
        if (acc) begin
            pend      = 1'b1;
            cd        = lat;
            stale     = redir;
            pend_addr = bus.imem_addr_o;
            acc_q.push_back(bus.imem_addr_o);
        end else if (pend && redir) begin
            stale = 1'b1;
        end
        if (redir) m_pc = tgt & 32'hFFFF_FFFC;
        else if (hs) begin
            m_pc  = m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
        end
        idle = (redir || hs) ? 0 : idle + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst                  = 1'b1;
        bus.redirect_valid_i = 1'b0;
        bus.inst_ready_i     = 1'b0;
        bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        pend         = 1'b0;
        m_pc         = RST_PC;
        m_cnt        = 32'd0;
        want_valid   = 1'b0;
        want_novalid = 1'b0;
        want_req     = 1'b0;
        want_hold    = 1'b0;
        idle         = 0;
        check("rst_req_valid", 32'(bus.imem_req_valid_o), 32'd1);
        check("rst_addr", bus.imem_addr_o, RST_PC);
        check("rst_inst_valid", 32'(bus.inst_valid_o), 32'd0);
        check("rst_inst", bus.inst_o, 32'd0);
        check("rst_pc", bus.pc_o, RST_PC);
        check("rst_cnt", bus.fetch_cnt_o, 32'd0);
    endtask

    task automatic run_to_valid();
        for (int i = 0; i < 30; i++) begin
            if (bus.inst_valid_o) break;
            step(1'b0, 32'd0, 1'b0, 1'b1, 1);
        end
        check("reach_valid", 32'(bus.inst_valid_o), 32'd1);
    endtask

    initial begin
        rst                  = 1'b1;
        bus.redirect_valid_i = 1'b0;
        bus.redirect_pc_i    = 32'd0;
        bus.inst_ready_i     = 1'b0;
        bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = 32'd0;
        @(posedge clk);
        #1;
        do_reset();

        // Zero-wait memory, always-ready decoder: one instruction every 3 cycles.
        acc_q.delete();
        for (int i = 0; i < 9; i++) begin
            check("zw_req", 32'(bus.imem_req_valid_o), 32'(i % 3 == 0));
            check("zw_valid", 32'(bus.inst_valid_o), 32'(i % 3 == 2));
            step(1'b0, 32'd0, 1'b1, 1'b1, 1);
        end
        check("zw_cnt", bus.fetch_cnt_o, 32'd3);
        check("zw_nreq", 32'(acc_q.size()), 32'd3);
        check("zw_addr0", acc_q[0], 32'h8000_0000);
        check("zw_addr1", acc_q[1], 32'h8000_0004);
        check("zw_addr2", acc_q[2], 32'h8000_0008);

        // Decoder backpressure for 5 cycles.
        run_to_valid();
        saved_pc   = bus.pc_o;
        saved_inst = bus.inst_o;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.inst_valid_o), 32'd1);
            check("bp_noreq", 32'(bus.imem_req_valid_o), 32'd0);
            check("bp_pc", bus.pc_o, saved_pc);
            check("bp_inst", bus.inst_o, saved_inst);
            step(1'b0, 32'd0, 1'b0, 1'b1, 1);
        end
        step(1'b0, 32'd0, 1'b1, 1'b1, 1);
        check("bp_next_req", 32'(bus.imem_req_valid_o), 32'd1);
        check("bp_next_addr", bus.imem_addr_o, saved_pc + 32'd4);

        // Redirect while waiting for the response.
        step(1'b0, 32'd0, 1'b0, 1'b1, 2);
        check("wait_state", 32'({bus.imem_req_valid_o, bus.inst_valid_o}), 32'd0);
        step(1'b1, 32'h8000_1003, 1'b0, 1'b1, 1);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1);
        check("wredir_req", 32'(bus.imem_req_valid_o), 32'd1);
        check("wredir_addr", bus.imem_addr_o, 32'h8000_1000);
        run_to_valid();
        check("wredir_pc", bus.pc_o, 32'h8000_1000);

        // Redirect in the same cycle as the response.
        step(1'b0, 32'd0, 1'b1, 1'b1, 1);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1);
        step(1'b1, 32'h8000_2008, 1'b0, 1'b1, 1);
        check("rsp_redir_addr", bus.imem_addr_o, 32'h8000_2008);
        run_to_valid();
        check("rsp_redir_pc", bus.pc_o, 32'h8000_2008);

        // Redirect in the same cycle as request acceptance.
        step(1'b0, 32'd0, 1'b1, 1'b1, 1);
        step(1'b1, 32'h8000_3010, 1'b0, 1'b1, 1);
        run_to_valid();
        check("acc_redir_pc", bus.pc_o, 32'h8000_3010);

        // Redirect in OUT with the decoder ready: no handshake counted.
        saved_cnt = bus.fetch_cnt_o;
        step(1'b1, 32'h8000_4000, 1'b1, 1'b1, 1);
        check("out_redir_cnt", bus.fetch_cnt_o, saved_cnt);
        check("out_redir_valid", 32'(bus.inst_valid_o), 32'd0);
        check("out_redir_req", 32'(bus.imem_req_valid_o), 32'd1);
        check("out_redir_addr", bus.imem_addr_o, 32'h8000_4000);

        // Reset mid-transaction, then a redirect to the top of the address space.
        step(1'b0, 32'd0, 1'b0, 1'b1, 3);
        check("wait_state2", 32'({bus.imem_req_valid_o, bus.inst_valid_o}), 32'd0);
        do_reset();
        step(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
        check("top_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
        run_to_valid();
        check("top_pc", bus.pc_o, 32'hFFFF_FFFC);
        step(1'b0, 32'd0, 1'b1, 1'b1, 1);
        check("wrap_req", 32'(bus.imem_req_valid_o), 32'd1);
        check("wrap_addr", bus.imem_addr_o, 32'd0);
        run_to_valid();
        check("wrap_pc", bus.pc_o, 32'd0);

        // Random traffic: memory stalls and latency, decoder backpressure, redirects anywhere.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 12) == 0, $urandom, $urandom % 2 == 1,
                 ($urandom % 3) != 0, int'($urandom_range(1, 3)));
        end
        check("random_progress", 32'(m_cnt > 32'd100), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ysyx_22041211_ifu.md
# ysyx_22041211_ifu

Instruction fetch unit of the NPC core, directly upstream of `ysyx_22041211_decoder`. It owns the architectural fetch PC and issues one request at a time to the instruction memory over a valid/ready interface. It buffers the returned word and presents `{inst, pc}` to the decoder with a valid/ready handshake. It also applies jump/branch redirects from downstream and discards in-flight responses made stale by a redirect.

## Interface
Parameters:
- `RESET_PC`, default `32'h8000_0000`: fetch address after reset.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `redirect_valid_i` in 1: one-cycle pulse; next fetch must come from `redirect_pc_i`.
- `redirect_pc_i` in 32: redirect target; bits [1:0] ignored, treated as 00.
- `imem_req_valid_o` out 1: fetch request valid.
- `imem_req_ready_i` in 1: memory accepts request; handshake when valid & ready.
- `imem_addr_o` out 32: fetch address; always equals the internal `pc`.
- `imem_rsp_valid_i` in 1: response valid, one cycle per accepted request, never in the acceptance cycle.
- `imem_rsp_data_i` in 32: instruction word.
- `inst_valid_o` out 1: instruction available to decoder.
- `inst_ready_i` in 1: decoder consumes; handshake when valid & ready.
- `inst_o` out 32: buffered instruction (decoder `inst_i`).
- `pc_o` out 32: PC of `inst_o` (decoder `pc_i`).
- `fetch_cnt_o` out 32: count of instructions delivered to the decoder (completed handshakes).

## Operation
- Registers: `pc`[31:0], `state` in {REQ, WAIT, OUT}, `kill`, `inst_buf`[31:0], `fetch_cnt`[31:0].
- Reset (`rst`=1 at an edge): `pc`<=RESET_PC, `state`<=REQ, `kill`<=0, `inst_buf`<=0, `fetch_cnt`<=0. Reset overrides everything, including mid-transaction; the first cycle after reset drives a request for RESET_PC. The memory is reset in the same cycle, so no stale response arrives.
- Reset values of outputs during the cycle after reset: `imem_req_valid_o`=1, `imem_addr_o`=RESET_PC, `inst_valid_o`=0, `inst_o`=0, `pc_o`=RESET_PC, `fetch_cnt_o`=0.
- Outputs are decoded from state: `imem_req_valid_o` = (state==REQ); `inst_valid_o` = (state==OUT); `inst_o`=`inst_buf`; `pc_o`=`pc`.
- REQ:
  - Request accepted, no redirect: go to WAIT.
  - Request accepted and redirect in the same cycle: go to WAIT, `kill`<=1, `pc`<=redirect target.
  - Request not accepted and redirect: `pc`<=redirect target and stay in REQ. The address may change while the request is unaccepted.
- WAIT:
  - Response arrives, `kill`=0: `inst_buf`<=data, go to OUT.
  - Response arrives, `kill`=1: discard it, `kill`<=0, go to REQ.
  - Redirect with no response: `pc`<=target, `kill`<=1, stay in WAIT.
  - Redirect and response in the same cycle: discard the response, `pc`<=target, `kill`<=0, go to REQ.
- OUT:
  - Redirect: drop the buffered instruction, `pc`<=target, go to REQ. Redirect has priority over `inst_ready_i`; no handshake is counted.
  - Else `inst_ready_i`=1: `pc`<=`pc`+4 (mod 2^32, so `32'hFFFF_FFFC` wraps to 0), `fetch_cnt`++ (wraps), go to REQ.
  - Else hold `inst_o`/`pc_o` stable.
- Redirect target is always `{redirect_pc_i[31:2],2'b00}`.
- At most one outstanding memory request; a killed response is the only one that can be dropped.

## Timing
- Zero-wait memory (ready=1, response one cycle after acceptance):
  - REQ at cycle N.
  - Response at N+1.
  - `inst_valid_o` at N+2.
  - If consumed at N+2, the next REQ is at N+3.
  - Steady throughput is 1 instruction per 3 cycles.
- Response to `inst_valid_o`: exactly 1 cycle (registered buffer); no combinational path from `imem_rsp_*` to `inst_*`.
- Handshake to next request: 1 cycle.
- Redirect in OUT: `inst_valid_o` drops the next cycle, and a request for the target is issued that same next cycle.
- No combinational path from `inst_ready_i` or `redirect_valid_i` to any output.

## Test plan
- Reset release, memory ready=1 with 1-cycle latency, decoder ready=1: addresses 80000000, 80000004, 80000008 on successive REQs. `pc_o`/`inst_o` match the memory image. `fetch_cnt_o`=3 after the third handshake.
- Backpressure: `inst_ready_i`=0 for 5 cycles while in OUT. `inst_valid_o`, `inst_o` and `pc_o` stay stable and no new request is issued. On release, the next address is `pc`+4.
- Redirect in WAIT (target 80001003): the in-flight response is discarded, and `inst_valid_o` never shows the old word. The next request address is 80001000.
- Same-cycle redirect and response, and same-cycle redirect and request acceptance: no stale instruction is delivered, and the next delivered `pc_o` is the target.
- Redirect in OUT with `inst_ready_i`=1 in the same cycle: `fetch_cnt_o` is unchanged and the next request is the target.
- `rst` asserted while in WAIT, then redirect target FFFFFFFC followed by a handshake: after reset, the fetch restarts at RESET_PC. In the redirect case, the fetch after FFFFFFFC is address 00000000.
